// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the two-master bus arbiter
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = M_CPU;
        // On a tie the master that lost last time wins.
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = M_DMA;
        end
    end

endmodule

// File: rtl/bus_arbiter2.sv
// rtl/bus_arbiter2.sv - two-master round-robin arbiter and bus sequencer with access timeout
module bus_arbiter2
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_en,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_we,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ack
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                s_en_q, s_en_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic                s_we_q, s_we_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0]   s_wstrb_q, s_wstrb_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          err_q, err_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    logic                arb_grant, arb_valid;
    logic                timeout_hit;
    logic                rsp_fire, rsp_err;
    logic [DATA_W-1:0]   rsp_data;

    rr_arb2 u_arb (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_valid) state_d = ST_ACCESS;
            ST_ACCESS: if (s_ack || timeout_hit) state_d = ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_en_d       = s_en_q;
        s_addr_d     = s_addr_q;
        s_we_d       = s_we_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        rsp_fire     = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    s_en_d       = 1'b1;
                    cnt_d        = '0;
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    if (arb_grant == M_DMA) begin
                        s_addr_d  = m1_addr;
                        s_we_d    = m1_we;
                        s_wdata_d = m1_wdata;
                        s_wstrb_d = m1_wstrb;
                    end else begin
                        s_addr_d  = m0_addr;
                        s_we_d    = m0_we;
                        s_wdata_d = m0_wdata;
                        s_wstrb_d = m0_wstrb;
                    end
                end
            end
            ST_ACCESS: begin
                // A late ack in the terminal cycle still beats the timeout.
                if (s_ack) begin
                    s_en_d   = 1'b0;
                    rsp_fire = 1'b1;
                    rsp_data = s_we_q ? '0 : s_rdata;
                end else if (timeout_hit) begin
                    s_en_d   = 1'b0;
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        ack_d    = {rsp_fire & grant_q, rsp_fire & ~grant_q};
        err_d    = {rsp_err & grant_q, rsp_err & ~grant_q};
        rdata0_d = (rsp_fire && grant_q == M_CPU) ? rsp_data : '0;
        rdata1_d = (rsp_fire && grant_q == M_DMA) ? rsp_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            grant_q      <= M_CPU;
            last_grant_q <= M_DMA;
            s_en_q       <= 1'b0;
            s_addr_q     <= '0;
            s_we_q       <= 1'b0;
            s_wdata_q    <= '0;
            s_wstrb_q    <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_en_q       <= s_en_d;
            s_addr_q     <= s_addr_d;
            s_we_q       <= s_we_d;
            s_wdata_q    <= s_wdata_d;
            s_wstrb_q    <= s_wstrb_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign s_en     = s_en_q;
    assign s_addr   = s_addr_q;
    assign s_we     = s_we_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb/tb_bus_arbiter2.sv - scoreboard bench for bus_arbiter2
module tb_bus_arbiter2;

    localparam int          T = 8;
    localparam logic [31:0] K = 32'h5A5A_A5A5;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          gap;
        bit          wiggle;
    } stim_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          len;
    } rsp_t;

    typedef struct {
        int m;
        int cyc;
    } glog_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req [2];
    logic [31:0] addr [2];
    logic        we [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        ack [2];
    logic        err [2];
    logic [31:0] rdata [2];
    logic        s_en, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    stim_t stim_q [2][$];
    rsp_t  exp_q [2][$];
    glog_t glog [$];
    bit    busy [2];
    bit    have_nxt [2];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    logic        snap_req [2];
    logic [31:0] snap_addr [2];
    logic        snap_we [2];
    logic [31:0] snap_wdata [2];
    logic [3:0]  snap_wstrb [2];

    bus_arbiter2 #(.TIMEOUT(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (req[0]),
        .m0_addr  (addr[0]),
        .m0_we    (we[0]),
        .m0_wdata (wdata[0]),
        .m0_wstrb (wstrb[0]),
        .m0_ack   (ack[0]),
        .m0_err   (err[0]),
        .m0_rdata (rdata[0]),
        .m1_req   (req[1]),
        .m1_addr  (addr[1]),
        .m1_we    (we[1]),
        .m1_wdata (wdata[1]),
        .m1_wstrb (wstrb[1]),
        .m1_ack   (ack[1]),
        .m1_err   (err[1]),
        .m1_rdata (rdata[1]),
        .s_en     (s_en),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_rdata  (s_rdata),
        .s_ack    (s_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Slave memory contents; addr[3:0] sets the ack delay, top nibble 3 is unmapped.
    function automatic logic [31:0] slave_data(logic [31:0] a);
        case (a)
            32'h2000_0010: return 32'hDEAD_BEEF;
            32'h2000_0007: return 32'h1234_5678;
            default:       return a ^ K;
        endcase
    endfunction

    function automatic bit is_mapped(logic [31:0] a);
        return a[31:28] != 4'h3;
    endfunction

    function automatic rsp_t model(stim_t s);
        rsp_t r;
        int   d;
        d = int'(s.addr[3:0]);
        if (is_mapped(s.addr) && d + 1 <= T) begin
            r.err   = 1'b0;
            r.rdata = s.we ? 32'h0 : slave_data(s.addr);
            r.len   = d + 1;
        end else begin
            r.err   = 1'b1;
            r.rdata = 32'h0;
            r.len   = T;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int m = 0; m < 2; m++) begin
            snap_req[m]   <= req[m];
            snap_addr[m]  <= addr[m];
            snap_we[m]    <= we[m];
            snap_wdata[m] <= wdata[m];
            snap_wstrb[m] <= wstrb[m];
        end
    end

    initial begin : slave
        int n;
        n = 0;
        s_ack = 1'b0;
        s_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!s_en) begin
                n = 0;
                s_ack = 1'($urandom);
                s_rdata = $urandom;
            end else begin
                n++;
                if (is_mapped(s_addr) && n == int'(s_addr[3:0]) + 1) begin
                    s_ack = 1'b1;
                    s_rdata = slave_data(s_addr);
                end else begin
                    s_ack = 1'b0;
                    s_rdata = $urandom;
                end
            end
        end
    end

    initial begin : masters
        stim_t cur [2];
        stim_t nxt [2];
        int    gap [2];
        int    age [2];
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; addr[m] = 32'h0; we[m] = 1'b0; wdata[m] = 32'h0; wstrb[m] = 4'h0;
            busy[m] = 1'b0; have_nxt[m] = 1'b0; gap[m] = 0; age[m] = 0;
        end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    req[m] = 1'b0;
                    busy[m] = 1'b0;
                    have_nxt[m] = 1'b0;
                end else begin
                    if (busy[m]) begin
                        if (ack[m]) begin
                            busy[m] = 1'b0;
                        end else begin
                            age[m]++;
                            if (cur[m].wiggle && age[m] == 2) addr[m] = cur[m].addr ^ 32'h0100_0000;
                        end
                    end
                    if (!busy[m]) begin
                        if (!have_nxt[m] && stim_q[m].size() > 0) begin
                            nxt[m] = stim_q[m].pop_front();
                            have_nxt[m] = 1'b1;
                            gap[m] = nxt[m].gap;
                        end
                        if (have_nxt[m] && gap[m] == 0) begin
                            cur[m] = nxt[m];
                            have_nxt[m] = 1'b0;
                            busy[m] = 1'b1;
                            age[m] = 0;
                            req[m] = 1'b1;
                            addr[m] = cur[m].addr;
                            we[m] = cur[m].we;
                            wdata[m] = cur[m].wdata;
                            wstrb[m] = cur[m].wstrb;
                            exp_q[m].push_back(model(cur[m]));
                        end else begin
                            if (have_nxt[m]) gap[m]--;
                            req[m] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: tracks transaction phase (0 idle, 1 access, 2 resp) and the round-robin model.
    initial begin : monitor
        int          ph;
        int          w;
        int          len;
        bit          last;
        logic [31:0] lat_addr;
        rsp_t        e;
        ph = 0; w = 0; len = 0; last = 1'b1; lat_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_s_en", s_en, 0);
                chk("rst_acks", {ack[1], ack[0]}, 0);
                ph = 0;
                last = 1'b1;
                exp_q[0].delete();
                exp_q[1].delete();
            end else begin
                case (ph)
                    0: begin
                        chk("idle_acks", {ack[1], ack[0]}, 0);
                        chk("start", s_en, snap_req[0] | snap_req[1]);
                        if (s_en) begin
                            if (snap_req[0] && snap_req[1]) w = last ? 0 : 1;
                            else w = snap_req[1] ? 1 : 0;
                            last = w[0];
                            glog.push_back('{w, cyc});
                            chk("grant_addr", s_addr, snap_addr[w]);
                            chk("grant_we", s_we, snap_we[w]);
                            chk("grant_wdata", s_wdata, snap_wdata[w]);
                            chk("grant_wstrb", s_wstrb, snap_wstrb[w]);
                            lat_addr = s_addr;
                            len = 1;
                            ph = 1;
                        end
                    end
                    1: begin
                        if (s_en) begin
                            len++;
                            chk("access_acks", {ack[1], ack[0]}, 0);
                            chk("frozen_addr", s_addr, lat_addr);
                            if (len > T) chk("access_len", len, T);
                        end else begin
                            ph = 2;
                            chk("ack_granted", ack[w], 1);
                            chk("other_ack", ack[1-w], 0);
                            chk("other_err", err[1-w], 0);
                            chk("other_rdata", rdata[1-w], 0);
                            if (exp_q[w].size() == 0) begin
                                chk("exp_avail", exp_q[w].size(), 1);
                            end else begin
                                e = exp_q[w].pop_front();
                                chk("rsp_err", err[w], e.err);
                                chk("rsp_rdata", rdata[w], e.rdata);
                                chk("en_len", len, e.len);
                            end
                        end
                    end
                    default: begin
                        chk("resp_exit_en", s_en, 0);
                        chk("resp_exit_acks", {ack[1], ack[0]}, 0);
                        ph = 0;
                    end
                endcase
            end
        end
    end

    function automatic stim_t mk(logic [31:0] a, logic w, int gap, bit wig);
        stim_t s;
        s.addr = a; s.we = w; s.wdata = $urandom; s.wstrb = 4'($urandom);
        s.gap = gap; s.wiggle = wig;
        return s;
    endfunction

    task automatic wait_done(string name, int limit);
        int n;
        n = 0;
        while (stim_q[0].size() || stim_q[1].size() || have_nxt[0] || have_nxt[1] ||
               busy[0] || busy[1] || exp_q[0].size() || exp_q[1].size()) begin
            @(posedge clk);
            n++;
            if (n > limit) begin
                total++;
                bad++;
                $display("FAIL wait_done %s: still busy after %0d cycles", name, n);
                break;
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : main
        logic [31:0] a;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_s_addr", s_addr, 0);
        chk("reset_s_we", s_we, 0);
        chk("reset_s_wdata", s_wdata, 0);
        chk("reset_s_wstrb", s_wstrb, 0);
        chk("reset_m0", {ack[0], err[0], rdata[0]}, 0);
        chk("reset_m1", {ack[1], err[1], rdata[1]}, 0);
        #2 rst_n = 1'b1;

        @(posedge clk);
        stim_q[0].push_back(mk(32'h2000_0010, 1'b0, 0, 1'b0));
        wait_done("single_read", 50);

        do_reset();
        @(posedge clk);
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            stim_q[0].push_back(mk(32'h2000_0000, 1'b0, 0, 1'b0));
            stim_q[1].push_back(mk(32'h2000_0010 | 32'(i), 1'b1, 0, 1'b0));
            stim_q[1][i].addr = 32'h2000_0010;
        end
        wait_done("contention", 100);
        chk("contention_grants", glog.size() >= 4, 1);
        if (glog.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("contention_order", glog[i].m, i % 2);
            for (int i = 1; i < 4; i++) chk("contention_gap", glog[i].cyc - glog[i-1].cyc, 3);
        end

        @(posedge clk);
        stim_q[1].push_back(mk(32'h3000_0000, 1'b1, 0, 1'b0));
        wait_done("timeout", 50);

        @(posedge clk);
        stim_q[0].push_back(mk(32'h2000_0007, 1'b0, 0, 1'b0));
        wait_done("ack_vs_timeout", 50);

        @(posedge clk);
        stim_q[0].push_back(mk(32'h4000_0005, 1'b0, 0, 1'b1));
        wait_done("freeze", 50);

        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 40; i++) begin
                a = $urandom;
                a[31:28] = 4'(2 + $urandom_range(0, 2));
                a[4] = m[0];
                a[3:0] = 4'($urandom_range(0, 11));
                stim_q[m].push_back(mk(a, 1'($urandom), $urandom_range(0, 3), 1'b0));
            end
        end
        wait_done("random", 4000);

        @(posedge clk);
        stim_q[0].push_back(mk(32'h3000_0000, 1'b0, 0, 1'b0));
        for (int i = 0; i < 20 && !s_en; i++) @(negedge clk);
        chk("midreset_started", s_en, 1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_s_en", s_en, 0);
        chk("midreset_acks", {ack[1], ack[0]}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        glog.delete();
        stim_q[0].push_back(mk(32'h2000_0001, 1'b0, 0, 1'b0));
        stim_q[1].push_back(mk(32'h2000_0012, 1'b0, 0, 1'b0));
        wait_done("after_reset", 100);
        chk("after_reset_grants", glog.size(), 2);
        if (glog.size() >= 1) chk("after_reset_first", glog[0].m, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
